// File: rtl/seg_pkg.sv
// seg_pkg: shared seven-segment constants, decode table and display buffer type
package seg_pkg;
    localparam int NUM_DIGITS = 4;
    localparam logic [3:0] AN_OFF = 4'hF;
    localparam logic [6:0] SEG_OFF = 7'h7F;
    // Active-low gfedcba patterns, indexed by hex value
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    typedef enum logic {PH_BLANK, PH_SHOW} phase_e;
    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  dp;
        logic [3:0]  en;
    } disp_buf_t;
endpackage

// File: rtl/hex_to_7seg.sv
// hex_to_7seg: combinational hex nibble to active-low seven-segment pattern
module hex_to_7seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);
    assign seg_o = SEG_TABLE[nibble_i];
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit seven-segment scan controller with frame-aligned double buffering
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int TICK_DIV  = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  digit_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        load_ack,
    output logic        frame_done
);
    localparam int CW = $clog2(TICK_DIV);

    disp_buf_t     act_q, pend_q, in_buf;
    logic          pend_valid_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    dig_q, dig_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d, seg_w;
    logic          dp_q, dp_d, load_ack_q, frame_done_q;
    logic          last_slot, commit, show;
    phase_e        phase;

    assign in_buf = {digits, dp_in, digit_en};

    hex_to_7seg u_dec (
        .nibble_i(act_q.digits[{dig_q, 2'b00} +: 4]),
        .seg_o   (seg_w)
    );

    always_comb begin
        phase     = cnt_q < CW'(BLANK_CYC) ? PH_BLANK : PH_SHOW;
        show      = phase == PH_SHOW && act_q.en[dig_q];
        last_slot = cnt_q == CW'(TICK_DIV - 1);
        commit    = last_slot && dig_q == 2'(NUM_DIGITS - 1);
        cnt_d     = last_slot ? '0 : cnt_q + 1'b1;
        dig_d     = last_slot ? dig_q + 1'b1 : dig_q;
        an_d      = show ? ~(4'b0001 << dig_q) : AN_OFF;
        seg_d     = show ? seg_w : SEG_OFF;
        dp_d      = show ? ~act_q.dp[dig_q] : 1'b1;
    end

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            cnt_q        <= '0;
            dig_q        <= '0;
            act_q        <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_OFF;
            dp_q         <= 1'b1;
            load_ack_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            dig_q        <= dig_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= commit;
            load_ack_q   <= commit && pend_valid_q;
            if (commit && pend_valid_q)
                act_q <= pend_q;
            // A load in the commit cycle stays pending for the following frame
            if (load) begin
                pend_q       <= in_buf;
                pend_valid_q <= 1'b1;
            end else if (commit) begin
                pend_valid_q <= 1'b0;
            end
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign load_ack   = load_ack_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: randomized and directed checks of seg_scan_ctrl against a frame-level model
module tb_seg_scan_ctrl;
    localparam int TD = 10;
    localparam int BL = 2;
    localparam int FR = 4 * TD;

    logic        clk_in, reset, load;
    logic [15:0] digits;
    logic [3:0]  dp_in, digit_en;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp, load_ack, frame_done;

    int total = 0;
    int bad = 0;

    seg_scan_ctrl #(.TICK_DIV(TD), .BLANK_CYC(BL)) dut (
        .clk_in(clk_in), .reset(reset), .load(load), .digits(digits), .dp_in(dp_in),
        .digit_en(digit_en), .an(an), .seg(seg), .dp(dp), .load_ack(load_ack),
        .frame_done(frame_done)
    );

    initial begin
        clk_in = 0;
        forever #5 clk_in = ~clk_in;
    end

    logic [6:0]  tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    int          m_n, m_pos, m_d;
    logic [15:0] a_dig, p_dig;
    logic [3:0]  a_dp, a_en, p_dp, p_en;
    logic        m_pv, m_show, m_end;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_ack, e_fd;

    // Model: m_n counts cycles since reset release; slot and frame position follow arithmetically
    always @(posedge clk_in) begin
        if (!reset) begin
            m_n = 0; a_dig = 0; a_dp = 0; a_en = 0; p_dig = 0; p_dp = 0; p_en = 0; m_pv = 0;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1; e_ack = 0; e_fd = 0;
        end else begin
            m_pos  = m_n % TD;
            m_d    = (m_n / TD) % 4;
            m_show = m_pos >= BL && a_en[m_d];
            e_an   = m_show ? ~(4'b0001 << m_d) : 4'hF;
            e_seg  = m_show ? tbl[a_dig[m_d*4 +: 4]] : 7'h7F;
            e_dp   = m_show ? ~a_dp[m_d] : 1'b1;
            m_end  = (m_n % FR) == FR - 1;
            e_fd   = m_end;
            e_ack  = m_end && m_pv;
            if (m_end && m_pv) begin
                a_dig = p_dig; a_dp = p_dp; a_en = p_en; m_pv = 0;
            end
            if (load) begin
                p_dig = digits; p_dp = dp_in; p_en = digit_en; m_pv = 1;
            end
            m_n++;
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic run_cycles(input string name, input int n, output int fds, output int acks);
        fds = 0;
        acks = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            total++;
            if ({an, seg, dp, load_ack, frame_done} !== {e_an, e_seg, e_dp, e_ack, e_fd}) begin
                bad++;
                $display("FAIL %s n=%0d: got an=%b seg=%h dp=%b ack=%b fd=%b, want an=%b seg=%h dp=%b ack=%b fd=%b",
                         name, m_n - 1, an, seg, dp, load_ack, frame_done, e_an, e_seg, e_dp, e_ack, e_fd);
            end
            fds += int'(frame_done);
            acks += int'(load_ack);
        end
    endtask

    task automatic sync_frame(input string name);
        int f, a;
        run_cycles(name, (FR - m_n % FR) % FR, f, a);
    endtask

    task automatic test_reset();
        int fd_at, f, a;
        reset = 0;
        repeat (3) begin
            tick();
            total++;
            if ({an, seg, dp, load_ack, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL reset_hold: got an=%b seg=%h dp=%b ack=%b fd=%b, want an=1111 seg=7f dp=1 ack=0 fd=0",
                         an, seg, dp, load_ack, frame_done);
            end
        end
        reset = 1;
        fd_at = -1;
        for (int k = 1; k <= FR; k++) begin
            run_cycles("after_reset", 1, f, a);
            if (f == 1 && fd_at < 0) fd_at = k;
        end
        total++;
        if (fd_at !== FR) begin
            bad++;
            $display("FAIL first_frame_done: got cycle %0d, want %0d", fd_at, FR);
        end
    endtask

    task automatic test_load_show();
        int f, a;
        logic [3:0] x_an [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [6:0] x_seg [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
        logic       x_dp [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        sync_frame("ls_sync");
        run_cycles("ls_pre", 13, f, a);
        digits = 16'h1234; dp_in = 4'b0001; digit_en = 4'hF; load = 1;
        run_cycles("ls_load", 1, f, a);
        load = 0; digits = 16'($urandom); dp_in = 4'($urandom);
        run_cycles("ls_wait", FR - m_n % FR, f, a);
        total++;
        if (f !== 1 || a !== 1 || !(load_ack && frame_done)) begin
            bad++;
            $display("FAIL ls_commit: got fd=%0d ack=%0d last=%b%b, want fd=1 ack=1 last=11", f, a, load_ack, frame_done);
        end
        for (int k = 1; k <= FR; k++) begin
            run_cycles("ls_frame", 1, f, a);
            if (k % 10 == 3) begin
                total++;
                if ({an, seg, dp} !== {x_an[k/10], x_seg[k/10], x_dp[k/10]}) begin
                    bad++;
                    $display("FAIL ls_digit%0d: got an=%b seg=%h dp=%b, want an=%b seg=%h dp=%b",
                             k / 10, an, seg, dp, x_an[k/10], x_seg[k/10], x_dp[k/10]);
                end
            end
        end
    endtask

    task automatic test_enable();
        int f, a;
        sync_frame("en_sync");
        digits = 16'($urandom); dp_in = 4'($urandom); digit_en = 4'b0101; load = 1;
        run_cycles("en_load", 1, f, a);
        load = 0;
        run_cycles("en_wait", FR - 1, f, a);
        total++;
        if (a !== 1) begin
            bad++;
            $display("FAIL en_commit: got ack=%0d, want 1", a);
        end
        for (int k = 1; k <= FR; k++) begin
            run_cycles("en_frame", 1, f, a);
            if (((k - 1) / TD) % 2 == 1) begin
                total++;
                if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
                    bad++;
                    $display("FAIL en_dark k=%0d: got an=%b seg=%h dp=%b, want an=1111 seg=7f dp=1", k, an, seg, dp);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int f, a, acks;
        logic [6:0] x_seg [4] = '{7'h40, 7'h40, 7'h0E, 7'h00};
        sync_frame("bb_sync");
        run_cycles("bb_pre", 5, f, a);
        digits = 16'hAAAA; dp_in = 4'h0; digit_en = 4'hF; load = 1;
        run_cycles("bb_load1", 1, f, a);
        load = 0;
        run_cycles("bb_mid", 10, f, a);
        digits = 16'h8F00; load = 1;
        run_cycles("bb_load2", 1, f, a);
        load = 0;
        run_cycles("bb_wait", FR - m_n % FR, f, acks);
        acks += a;
        for (int k = 1; k <= FR; k++) begin
            run_cycles("bb_frame", 1, f, a);
            acks += a;
            if (k % 10 == 3) begin
                total++;
                if (seg !== x_seg[k/10]) begin
                    bad++;
                    $display("FAIL bb_digit%0d: got seg=%h, want %h", k / 10, seg, x_seg[k/10]);
                end
            end
        end
        total++;
        if (acks !== 1) begin
            bad++;
            $display("FAIL bb_acks: got %0d, want 1", acks);
        end
    endtask

    task automatic test_load_at_commit();
        int f, a;
        sync_frame("lc_sync");
        run_cycles("lc_pre", FR - 1, f, a);
        digits = 16'($urandom); dp_in = 4'($urandom); digit_en = 4'hF; load = 1;
        run_cycles("lc_load", 1, f, a);
        load = 0;
        total++;
        if ({frame_done, load_ack} !== 2'b10) begin
            bad++;
            $display("FAIL lc_commit_cycle: got fd=%b ack=%b, want fd=1 ack=0", frame_done, load_ack);
        end
        run_cycles("lc_next", FR, f, a);
        total++;
        if (f !== 1 || a !== 1) begin
            bad++;
            $display("FAIL lc_next_frame: got fd=%0d ack=%0d, want fd=1 ack=1", f, a);
        end
    endtask

    task automatic test_reset_mid();
        int f, a;
        sync_frame("rm_sync");
        digits = 16'($urandom); dp_in = 4'($urandom); digit_en = 4'hF; load = 1;
        run_cycles("rm_load", 1, f, a);
        load = 0;
        run_cycles("rm_pre", 2 * TD + 5 - m_n % FR, f, a);
        reset = 0;
        tick();
        reset = 1;
        total++;
        if ({an, seg, dp, load_ack, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL rm_blank: got an=%b seg=%h dp=%b ack=%b fd=%b, want an=1111 seg=7f dp=1 ack=0 fd=0",
                     an, seg, dp, load_ack, frame_done);
        end
        run_cycles("rm_after", FR - 1, f, a);
        total++;
        if (f !== 0 || a !== 0) begin
            bad++;
            $display("FAIL rm_quiet: got fd=%0d ack=%0d, want 0 0", f, a);
        end
        run_cycles("rm_end", 1, f, a);
        total++;
        if ({frame_done, load_ack} !== 2'b10) begin
            bad++;
            $display("FAIL rm_frame_end: got fd=%b ack=%b, want fd=1 ack=0", frame_done, load_ack);
        end
    endtask

    task automatic test_random();
        int f, a;
        for (int i = 0; i < 600; i++) begin
            load = $urandom_range(0, 24) == 0;
            digits = 16'($urandom);
            dp_in = 4'($urandom);
            digit_en = 4'($urandom);
            reset = $urandom_range(0, 299) != 0;
            run_cycles("random", 1, f, a);
        end
        load = 0;
        reset = 1;
        run_cycles("random_tail", 2 * FR, f, a);
    endtask

    initial begin
        reset = 0; load = 0; digits = 0; dp_in = 0; digit_en = 0;
        test_reset();
        test_load_show();
        test_enable();
        test_back_to_back();
        test_load_at_commit();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
